// File: rtl/part_select_pipe.sv
// part_select_pipe
// Two-stage elastic, runtime-indexed bit-field extractor.
// For a signed start index (window MSB) the block returns
//   out[OUT_WIDTH-1-k] = in[start-k], k = 0..OUT_WIDTH-1 (out-of-range bits read 0)
// together with a sticky flag (OR of bits below the window) and an overflow
// flag (OR of bits above the window).
//
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      source handshake (in_ready has no path from in_valid)
//   in_data  [IN_WIDTH]      source vector
//   in_start [IDX_WIDTH]     signed index of the window MSB
//   out_valid / out_ready    sink handshake
//   out_data [OUT_WIDTH]     extracted window, straight from the s2 register
//   out_sticky, out_overflow dropped-bit flags, straight from s2 registers
//
// Stage s1 captures the transaction and the two flags (computed from bit masks
// at the input). Stage s2 holds the shifted window. Latency is exactly 2.

module part_select_pipe #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [IDX_WIDTH-1:0] in_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sticky,
    output logic                 out_overflow
);

    // Source vector padded below by 2*OUT_WIDTH zeros so that a window whose
    // low end falls under bit 0 becomes a plain right shift.
    localparam int unsigned EXT_WIDTH   = IN_WIDTH + 2 * OUT_WIDTH;
    localparam int unsigned SHAMT_WIDTH = $clog2(EXT_WIDTH + 2);
    // Signed working width: holds every legal index and every shift amount.
    localparam int unsigned CALC_WIDTH  =
        ((IDX_WIDTH > SHAMT_WIDTH) ? IDX_WIDTH : SHAMT_WIDTH) + 2;

    // ------------------------------------------------------------------
    // Handshake / stage advance
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Input-side index arithmetic and flag masks
    // ------------------------------------------------------------------
    logic signed [CALC_WIDTH-1:0] in_hi;
    logic signed [CALC_WIDTH-1:0] in_lo;
    logic        [IN_WIDTH-1:0]   ovf_mask;
    logic        [IN_WIDTH-1:0]   stk_mask;

    assign in_hi = CALC_WIDTH'($signed(in_start));
    assign in_lo = in_hi - $signed(CALC_WIDTH'(OUT_WIDTH - 1));

    // Bit i is above the window when i > hi, below it when i < lo.
    always_comb begin
        ovf_mask = '0;
        stk_mask = '0;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            ovf_mask[i] = ($signed(CALC_WIDTH'(i)) > in_hi);
            stk_mask[i] = ($signed(CALC_WIDTH'(i)) < in_lo);
        end
    end

    // ------------------------------------------------------------------
    // Stage s1: captured transaction and precomputed flags
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0]  s1_data;
    logic [IDX_WIDTH-1:0] s1_start;
    logic                 s1_sticky;
    logic                 s1_overflow;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_start    <= '0;
            s1_sticky   <= 1'b0;
            s1_overflow <= 1'b0;
        end else if (s1_load) begin
            s1_valid    <= 1'b1;
            s1_data     <= in_data;
            s1_start    <= in_start;
            s1_sticky   <= |(in_data & stk_mask);
            s1_overflow <= |(in_data & ovf_mask);
        end else if (s2_load) begin
            s1_valid    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Window shift from s1 into s2
    // ------------------------------------------------------------------
    // in[i] sits at ext[i + 2*OUT_WIDTH]; out[j] = in[lo + j], so the right
    // shift is lo + 2*OUT_WIDTH = start + OUT_WIDTH + 1, which is >= 1 for
    // every legal start. Shifts past the top fill with zeros.
    logic signed [CALC_WIDTH-1:0] s1_hi;
    logic        [CALC_WIDTH-1:0] s1_shamt;
    logic        [EXT_WIDTH-1:0]  s1_ext;
    logic        [OUT_WIDTH-1:0]  s1_window;

    assign s1_hi     = CALC_WIDTH'($signed(s1_start));
    assign s1_shamt  = CALC_WIDTH'(s1_hi + $signed(CALC_WIDTH'(OUT_WIDTH + 1)));
    assign s1_ext    = {s1_data, {(2 * OUT_WIDTH){1'b0}}};
    assign s1_window = OUT_WIDTH'(s1_ext >> s1_shamt);

    // ------------------------------------------------------------------
    // Stage s2: output registers
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] s2_data;
    logic                 s2_sticky;
    logic                 s2_overflow;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_sticky   <= 1'b0;
            s2_overflow <= 1'b0;
        end else if (s2_load) begin
            s2_valid    <= 1'b1;
            s2_data     <= s1_window;
            s2_sticky   <= s1_sticky;
            s2_overflow <= s1_overflow;
        end else if (out_ready) begin
            s2_valid    <= 1'b0;
        end
    end

    assign out_valid    = s2_valid;
    assign out_data     = s2_data;
    assign out_sticky   = s2_sticky;
    assign out_overflow = s2_overflow;

endmodule

// File: tb/tb_part_select_pipe.sv
// Testbench for part_select_pipe: a default-parameter instance checked by a
// queue scoreboard fed from a direct bit-loop reference model, plus an
// 8-in/8-out instance checked against fixed expected values.

module tb_part_select_pipe;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned IDX_W = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;

    // default-parameter instance
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [IN_W-1:0]  in_data;
    logic [IDX_W-1:0] in_start;
    logic [OUT_W-1:0] out_data;
    logic             out_sticky, out_overflow;

    // 8-bit in / 8-bit out instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] in_data8, in_start8, out_data8;
    logic       out_sticky8, out_overflow8;

    part_select_pipe #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .IDX_WIDTH(IDX_W)) u_dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_start(in_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sticky(out_sticky), .out_overflow(out_overflow)
    );

    part_select_pipe #(.IN_WIDTH(8), .OUT_WIDTH(8), .IDX_WIDTH(8)) u_dut8 (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_start(in_start8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_sticky(out_sticky8), .out_overflow(out_overflow8)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: walk the window bit by bit; returns {overflow, sticky, out[31:0]}.
    function automatic logic [33:0] ref_extract(input logic [31:0] d, input int st,
                                                input int inw, input int outw);
        logic [31:0] o;
        logic        stk;
        logic        ovf;
        o   = '0;
        stk = 1'b0;
        ovf = 1'b0;
        for (int k = 0; k < outw; k++) begin
            int idx;
            idx = st - k;
            if (idx >= 0 && idx < inw) o[outw-1-k] = d[idx];
        end
        for (int i = 0; i < inw; i++) begin
            if (i > st) ovf = ovf | d[i];
            if (i < st - outw + 1) stk = stk | d[i];
        end
        return {ovf, stk, o};
    endfunction

    // Scoreboard for the default instance, sampled on the falling edge.
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    int          mon_st;
    int          n_out = 0;

    always @(negedge clock) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_data",     32'(out_data),     32'(mon_e[15:0]));
                    check("sb_sticky",   32'(out_sticky),   32'(mon_e[32]));
                    check("sb_overflow", 32'(out_overflow), 32'(mon_e[33]));
                    n_out++;
                end
            end
            if (in_valid) begin
                mon_st = int'($signed(in_start));
                assert (mon_st >= -int'(OUT_W) && mon_st <= int'(IN_W + OUT_W))
                    else $error("illegal in_start %0d", mon_st);
                if (in_ready) exp_q.push_back(ref_extract(in_data, mon_st, int'(IN_W), int'(OUT_W)));
            end
        end
    end

    // Step 1 table (in = 0xA5)
    int         st1[5] = '{7, 3, 9, -1, 15};
    logic [7:0] exo[5] = '{8'hA5, 8'h50, 8'h29, 8'h00, 8'h00};
    logic       exs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    int          base;
    int          sent;
    logic        fire;
    logic [15:0] held;
    logic [31:0] bp_d[4];
    int          bp_s[4];

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input int st);
        in_valid = 1'b1;
        in_data  = d;
        in_start = IDX_W'(st);
    endtask

    task automatic drain(input string tag, input int exp_count);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) next_cycle();
        next_cycle();
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_count"}, 32'(n_out - base), 32'(exp_count));
    endtask

    task automatic stream_run(input string tag, input int n, input bit zero);
        base = n_out;
        for (int i = 0; i < n; i++) begin
            if (zero) drive(32'd0, i - 16);
            else      drive($urandom(), int'($urandom_range(64)) - 16);
            @(negedge clock);
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            if (i >= 2) check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
            next_cycle();
        end
        in_valid = 1'b0;
        drain(tag, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0; in_data = '0; in_start = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_start8 = '0; out_ready8 = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_flags",     32'({out_sticky, out_overflow}), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // 1. 8/8 instance, fixed table, latency 2
        for (int t = 0; t < 5; t++) begin
            in_valid8 = 1'b1; in_data8 = 8'hA5; in_start8 = 8'(st1[t]);
            @(negedge clock);
            check($sformatf("t1_accept[%0d]", t), 32'(in_ready8), 32'd1);
            next_cycle();
            in_valid8 = 1'b0;
            @(negedge clock);
            check($sformatf("t1_lat1[%0d]", t), 32'(out_valid8), 32'd0);
            next_cycle();
            @(negedge clock);
            check($sformatf("t1_valid[%0d]", t), 32'(out_valid8), 32'd1);
            check($sformatf("t1_data[%0d]", t), 32'(out_data8), 32'(exo[t]));
            check($sformatf("t1_sticky[%0d]", t), 32'(out_sticky8), 32'(exs[t]));
            check($sformatf("t1_overflow[%0d]", t), 32'(out_overflow8), 32'(exv[t]));
            next_cycle();
        end

        // 2. zero data, start -16..48
        stream_run("t2", 65, 1'b1);

        // 3. random back-to-back
        stream_run("t3", 20, 1'b0);

        // 4. backpressure
        for (int i = 0; i < 4; i++) begin
            bp_d[i] = $urandom();
            bp_s[i] = int'($urandom_range(64)) - 16;
        end
        base = n_out; sent = 0; out_ready = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            if (sent < 4) drive(bp_d[sent], bp_s[sent]);
            else in_valid = 1'b0;
            @(negedge clock);
            fire = in_valid && in_ready;
            if (c == 2) held = out_data;
            if (c == 4) begin
                check("t4_held", 32'(out_data), 32'(held));
                check("t4_ready_low", 32'(in_ready), 32'd0);
                check("t4_valid", 32'(out_valid), 32'd1);
            end
            next_cycle();
            if (fire) sent++;
        end
        check("t4_stall_accepts", 32'(sent), 32'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sent < 4; c++) begin
            drive(bp_d[sent], bp_s[sent]);
            @(negedge clock);
            fire = in_valid && in_ready;
            next_cycle();
            if (fire) sent++;
        end
        in_valid = 1'b0;
        check("t4_sent", 32'(sent), 32'd4);
        drain("t4", 4);

        // 5. drain and fill in the same cycle
        base = n_out; out_ready = 1'b0;
        drive($urandom(), 5);  next_cycle();
        drive($urandom(), 30); next_cycle();
        drive($urandom(), -4);
        @(negedge clock);
        check("t5_full_ready", 32'(in_ready), 32'd0);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clock);
        check("t5_pulse_in_ready", 32'(in_ready), 32'd1);
        check("t5_pulse_out_valid", 32'(out_valid), 32'd1);
        next_cycle();
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("t5_occ_out_valid", 32'(out_valid), 32'd1);
        check("t5_occ_in_ready", 32'(in_ready), 32'd0);
        check("t5_one_out", 32'(n_out - base), 32'd1);
        next_cycle();
        out_ready = 1'b1;
        drain("t5", 3);

        // 6. asynchronous reset with both stages full
        out_ready = 1'b0;
        drive(32'hFFFF_FFFF, 20); next_cycle();
        drive(32'h1234_5678, 10); next_cycle();
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_data", 32'(out_data), 32'h0000_FFFF);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_flags", 32'({out_sticky, out_overflow}), 32'd0);
        next_cycle();
        resetn = 1'b1;
        out_ready = 1'b1;
        base = n_out;
        @(negedge clock);
        check("t6_post_in_ready", 32'(in_ready), 32'd1);
        check("t6_post_out_valid", 32'(out_valid), 32'd0);
        next_cycle();
        drive($urandom(), int'($urandom_range(64)) - 16);
        @(negedge clock);
        check("t6_accept", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clock);
        check("t6_lat1", 32'(out_valid), 32'd0);
        next_cycle();
        @(negedge clock);
        check("t6_lat2", 32'(out_valid), 32'd1);
        next_cycle();
        drain("t6", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/part_select_pipe.md
Name: part_select_pipe

Overview:
Pipelined, runtime-indexed bit-field extractor with a valid/ready handshake. It is the dynamic successor to the static part-select helper. The start index arrives per transaction as a signed value. The block also reports sticky and overflow flags for the bits dropped below and above the window. It sits in the float/posit normalize and round paths, where the shift amount is data-dependent, and in any datapath needing a windowed extract at one transaction per cycle.

Parameters:
IN_WIDTH, 32, width of the source vector
OUT_WIDTH, 16, width of the extracted window
IDX_WIDTH, 8, width of the signed start index; must hold -(OUT_WIDTH) .. IN_WIDTH+OUT_WIDTH

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  source offers a transaction
in_ready  output  1  block accepts when in_valid && in_ready
in_data  input  IN_WIDTH  source vector
in_start  input  IDX_WIDTH  signed index of the window MSB
out_valid  output  1  result available
out_ready  input  1  sink accepts when out_valid && out_ready
out_data  output  OUT_WIDTH  out[OUT_WIDTH-1-k] = in[start-k] for k = 0..OUT_WIDTH-1; out-of-range source bits read 0
out_sticky  output  1  OR of in bits with index < start-OUT_WIDTH+1
out_overflow  output  1  OR of in bits with index > start

Behaviour:
- Reset (async assert, sync deassert handled upstream): both stage valids clear, out_valid=0, out_data=0, out_sticky=0, out_overflow=0.
- Reset mid-operation: in-flight transactions are discarded, with no partial output.
- Two-stage elastic pipeline; register names s1 and s2.
  - s1 holds the captured in_data and in_start, plus precomputed sticky and overflow masks and flags.
  - s2 holds the shifted out_data and the registered flags. Outputs come directly from s2 registers.
- Latency: an accept in cycle N gives out_valid in cycle N+2 when the sink is not stalled.
- Throughput: 1 per cycle while out_ready=1.
- Stage advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - s1_load = in_valid && in_ready
  - in_ready = !s1_valid || s2_load; combinational from out_ready, with no path from in_valid
- Simultaneous drain and fill: when s2 is consumed and s1 moves into s2 in the same cycle, s1 may accept a new input that cycle. There are no bubbles and no lost or duplicated transactions.
- Under stall (out_valid && !out_ready):
  - out_data, out_sticky and out_overflow are held stable.
  - s1 holds one more transaction, then in_ready=0.
- Index arithmetic is signed, with no wrap. The low window index is lo = start-OUT_WIDTH+1. Boundary cases:
  - start >= IN_WIDTH: the top bits of out are 0; overflow=0.
  - lo < 0: the bottom bits of out are 0; sticky=0.
  - start < 0: out=0, sticky=0, overflow = |in_data.
  - lo > IN_WIDTH-1: out=0, overflow=0, sticky = |in_data.
  - in_data=0: out, sticky and overflow are all 0 for any start.
- in_start values outside the documented range are illegal. The verification bench asserts on them; the RTL behaviour for them is undefined.
- The mask/shift implementation is free: a barrel shifter split across stages is allowed, provided latency stays exactly 2.

Test Plan:
1. Use IN_WIDTH=8, OUT_WIDTH=8. Send in=0xA5 with each of the following starts; each result appears 2 cycles after accept.
   - start=7 -> out=0xA5, sticky=0, overflow=0.
   - start=3 -> out=0x50, sticky=0, overflow=1.
   - start=9 -> out=0x29, sticky=1 (in[1:0]=01), overflow=0.
   - start=-1 -> out=0x00, sticky=0, overflow=1.
   - start=15 -> out=0x00, sticky=1, overflow=0.
2. Default parameters, in=0, sweep start from -16 to 48 -> out=0, sticky=0, overflow=0 for every start.
3. Streaming: drive 20 back-to-back transactions with random in and start, out_ready=1 -> in_ready stays 1, one result per cycle, all match the model, order preserved.
4. Backpressure: offer 4 transactions continuously with out_ready=0 for 5 cycles -> in_ready drops after exactly 2 accepts; out_data held stable; after out_ready=1 all 4 emerge in order with none lost or duplicated.
5. Drain/fill: hold s1 and s2 full, then pulse out_ready=1 with in_valid=1 -> one output and one accept in the same cycle; the occupancy stays at 2.
6. Reset: assert resetn=0 asynchronously mid-clock while both stages are full -> out_valid=0 and flags=0 immediately; after release, in_ready=1 and the first new transaction's result appears 2 cycles after accept.
